// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : frame_buffer_pkg
// Brief  : Shared state encodings, default geometry and stats constants.
// Rev    : 1.0
// ============================================================================
package frame_buffer_pkg;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WIDLE = 2'd0;
  localparam wr_state_t WFILL = 2'd1;
  localparam wr_state_t WFULL = 2'd2;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RIDLE  = 1'b0;
  localparam rd_state_t RDRAIN = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W      = 320;
  localparam int DEF_IMG_H      = 240;
  localparam int DEF_RAM_DEPTH  = DEF_IMG_W * DEF_IMG_H;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_RAM_DEPTH);

  localparam logic [DEF_DATA_WIDTH-1:0] STAT_MIN_INIT = '1;

  function automatic int fb_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module : frame_buffer_if
// Brief  : Write/read stream bundle of the frame buffer (min/max with FB_STATS_EN).
// Rev    : 1.0
// ============================================================================
interface frame_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_start_i_fb;
  logic                  wr_valid_i_fb;
  logic [DATA_WIDTH-1:0] wr_data_i_fb;
  logic                  wr_ready_o_fb;
  logic                  wr_done_o_fb;
  logic                  full_o_fb;
  logic                  rd_start_i_fb;
  logic                  rd_valid_o_fb;
  logic [DATA_WIDTH-1:0] rd_data_o_fb;
  logic                  rd_last_o_fb;
  logic                  rd_ready_i_fb;
  logic                  rd_done_o_fb;
`ifdef FB_STATS_EN
  logic [DATA_WIDTH-1:0] min_o_fb;
  logic [DATA_WIDTH-1:0] max_o_fb;
`endif

  modport slave (
    input  wr_start_i_fb, wr_valid_i_fb, wr_data_i_fb, rd_start_i_fb, rd_ready_i_fb,
    output wr_ready_o_fb, wr_done_o_fb, full_o_fb,
    output rd_valid_o_fb, rd_data_o_fb, rd_last_o_fb, rd_done_o_fb
`ifdef FB_STATS_EN
    , output min_o_fb, max_o_fb
`endif
  );

  modport master (
    output wr_start_i_fb, wr_valid_i_fb, wr_data_i_fb, rd_start_i_fb, rd_ready_i_fb,
    input  wr_ready_o_fb, wr_done_o_fb, full_o_fb,
    input  rd_valid_o_fb, rd_data_o_fb, rd_last_o_fb, rd_done_o_fb
`ifdef FB_STATS_EN
    , input min_o_fb, max_o_fb
`endif
  );

endinterface
`default_nettype wire

// File: rtl/fb_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fb_skid_buf
// Brief  : 2-entry valid/ready output buffer for data+last, exposes occupancy.
// Rev    : 1.0
// ============================================================================
module fb_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready,
  output logic [1:0]       o_occ
);
  localparam int EW = WIDTH + 1;

  logic [EW-1:0] r_e0;
  logic [EW-1:0] r_e1;
  logic [1:0]    r_occ;
  logic [EW-1:0] w_in;
  logic          w_pop;

  assign w_in  = {i_last, i_data};
  assign w_pop = (r_occ != 2'd0) && i_ready;

  // r_e0 is always the head; it only moves on a pop, so outputs hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_valid) begin
            r_e0  <= w_in;
            r_occ <= 2'd1;
          end
        end
        2'd1: begin
          case ({i_valid, w_pop})
            2'b10: begin
              r_e1  <= w_in;
              r_occ <= 2'd2;
            end
            2'b01:   r_occ <= 2'd0;
            2'b11:   r_e0  <= w_in;
            default: r_occ <= r_occ;
          endcase
        end
        default: begin
          if (w_pop) begin
            r_e0 <= r_e1;
            if (i_valid) r_e1  <= w_in;
            else         r_occ <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_e0[WIDTH-1:0];
  assign o_last  = r_e0[WIDTH];
  assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_dp.sv
`default_nettype none
// ============================================================================
// Module : frame_buffer_dp
// Brief  : Single-frame block-RAM store, raster write in / raster read out.
//          Define FB_STATS_EN to add running min/max of the written frame.
// Rev    : 1.0
// ============================================================================
module frame_buffer_dp
  import frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H
) (
  input  logic          clk_i_fb,
  input  logic          rstn_i_fb,
  frame_buffer_if.slave fb
);
  localparam int RAM_DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_WIDTH = fb_addr_width(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_ram [RAM_DEPTH];

  wr_state_t             r_wstate;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wr_done;
  logic                  r_full;
  logic                  w_wr_ready;
  logic                  w_wr_fire;
  logic                  w_wr_go;

  rd_state_t             r_rstate;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_issue_done;
  logic                  r_inflight;
  logic                  r_last_inflight;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_rd_go;
  logic                  w_rd_active;
  logic                  w_issue;
  logic [1:0]            w_pending;

  logic                  w_sk_valid;
  logic [DATA_WIDTH-1:0] w_sk_data;
  logic                  w_sk_last;
  logic [1:0]            w_sk_occ;
  logic                  w_rd_pop;
  logic                  w_rd_done;

  assign w_wr_ready = (r_wstate == WFILL);
  assign w_wr_fire  = fb.wr_valid_i_fb && w_wr_ready;
  assign w_wr_go    = fb.wr_start_i_fb && (r_wstate == WIDLE) && !r_full;

  always_ff @(posedge clk_i_fb or negedge rstn_i_fb) begin
    if (!rstn_i_fb) begin
      r_wstate  <= WIDLE;
      r_waddr   <= '0;
      r_wr_done <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_wstate)
        WIDLE: begin
          if (w_wr_go) begin
            r_wstate <= WFILL;
            r_waddr  <= '0;
          end
        end
        WFILL: begin
          if (w_wr_fire) begin
            if (r_waddr == c_LAST_ADDR) begin
              r_waddr   <= '0;
              r_wr_done <= 1'b1;
              r_full    <= 1'b1;
              r_wstate  <= WFULL;
            end else begin
              r_waddr <= r_waddr + 1'b1;
            end
          end
        end
        WFULL: begin
          if (w_rd_done) begin
            r_full   <= 1'b0;
            r_wstate <= WIDLE;
          end
        end
        default: r_wstate <= WIDLE;
      endcase
    end
  end

  assign w_rd_go     = fb.rd_start_i_fb && (r_rstate == RIDLE) && r_full;
  assign w_rd_active = (r_rstate == RDRAIN) || w_rd_go;
  assign w_rd_pop    = w_sk_valid && fb.rd_ready_i_fb;
  assign w_rd_done   = w_rd_pop && w_sk_last;

  // A pop in this cycle frees a slot, which is what sustains one pixel per clock.
  assign w_pending = w_sk_occ + {1'b0, r_inflight} - {1'b0, w_rd_pop};
  assign w_issue   = w_rd_active && !r_issue_done && (w_pending < 2'd2);

  always_ff @(posedge clk_i_fb or negedge rstn_i_fb) begin
    if (!rstn_i_fb) begin
      r_rstate        <= RIDLE;
      r_raddr         <= '0;
      r_issue_done    <= 1'b0;
      r_inflight      <= 1'b0;
      r_last_inflight <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_last_inflight <= w_issue && (r_raddr == c_LAST_ADDR);
      if (w_issue) begin
        if (r_raddr == c_LAST_ADDR) begin
          r_raddr      <= '0;
          r_issue_done <= 1'b1;
        end else begin
          r_raddr <= r_raddr + 1'b1;
        end
      end
      case (r_rstate)
        RIDLE: begin
          if (w_rd_go) r_rstate <= RDRAIN;
        end
        default: begin
          if (w_rd_done) begin
            r_rstate     <= RIDLE;
            r_raddr      <= '0;
            r_issue_done <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i_fb) begin
    if (w_wr_fire) r_ram[r_waddr] <= fb.wr_data_i_fb;
    if (w_issue)   r_rdata        <= r_ram[r_raddr];
  end

  fb_skid_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk_i_fb),
    .rst_n   (rstn_i_fb),
    .i_valid (r_inflight),
    .i_data  (r_rdata),
    .i_last  (r_last_inflight),
    .o_valid (w_sk_valid),
    .o_data  (w_sk_data),
    .o_last  (w_sk_last),
    .i_ready (fb.rd_ready_i_fb),
    .o_occ   (w_sk_occ)
  );

  assign fb.wr_ready_o_fb = w_wr_ready;
  assign fb.wr_done_o_fb  = r_wr_done;
  assign fb.full_o_fb     = r_full;
  assign fb.rd_valid_o_fb = w_sk_valid;
  assign fb.rd_data_o_fb  = w_sk_data;
  assign fb.rd_last_o_fb  = w_sk_last;
  assign fb.rd_done_o_fb  = w_rd_done;

`ifdef FB_STATS_EN
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;

  always_ff @(posedge clk_i_fb or negedge rstn_i_fb) begin
    if (!rstn_i_fb) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_wr_go) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_wr_fire) begin
      if (fb.wr_data_i_fb < r_min) r_min <= fb.wr_data_i_fb;
      if (fb.wr_data_i_fb > r_max) r_max <= fb.wr_data_i_fb;
    end
  end

  assign fb.min_o_fb = r_min;
  assign fb.max_o_fb = r_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_dp.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_buffer_dp
// Brief  : Scoreboard bench for frame_buffer_dp on a 4x2 frame.
// Rev    : 1.0
// ============================================================================
module tb_frame_buffer_dp;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_rd_done = 0;
  int cyc_cnt   = 0;
  int t_start   = 0;
  int t_done    = 0;

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] frame [N];

  frame_buffer_if #(.DATA_WIDTH(DW)) fb_if ();

  frame_buffer_dp #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H)
  ) dut (
    .clk_i_fb  (clk),
    .rstn_i_fb (rst_n),
    .fb        (fb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Read-side scoreboard: every valid cycle is compared with the head entry.
  always @(negedge clk) begin : mon
    logic [DW:0] head;
    if (rst_n) begin
      if (fb_if.rd_done_o_fb && !(fb_if.rd_valid_o_fb && fb_if.rd_ready_i_fb))
        chk("rd_done_spurious", 32'(fb_if.rd_done_o_fb), 32'd0);
      if (fb_if.rd_valid_o_fb) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 32'(fb_if.rd_valid_o_fb), 32'd0);
        end else begin
          head = exp_q[0];
          chk("rd_data", 32'(fb_if.rd_data_o_fb), 32'(head[DW-1:0]));
          chk("rd_last", 32'(fb_if.rd_last_o_fb), 32'(head[DW]));
          if (fb_if.rd_ready_i_fb) begin
            chk("rd_done", 32'(fb_if.rd_done_o_fb), 32'(head[DW]));
            void'(exp_q.pop_front());
          end
        end
      end
      if (fb_if.rd_done_o_fb) begin
        n_rd_done++;
        t_done = cyc_cnt;
      end
    end
  end

  task automatic write_frame(input int pct, input int npix);
    int i;
    int budget;
    int early;
`ifdef FB_STATS_EN
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    mn = '1;
    mx = '0;
`endif
    i = 0;
    budget = 0;
    early = 0;
    @(posedge clk); #1;
    fb_if.wr_start_i_fb = 1'b1;
    @(posedge clk); #1;
    fb_if.wr_start_i_fb = 1'b0;
    while (i < npix && budget < 400) begin
      fb_if.wr_valid_i_fb = ($urandom_range(0, 99) < pct);
      fb_if.wr_data_i_fb  = frame[i];
      @(negedge clk);
      if (budget == 0) chk("wr_ready_fill", 32'(fb_if.wr_ready_o_fb), 32'd1);
      if (fb_if.wr_done_o_fb) early++;
      if (fb_if.wr_valid_i_fb && fb_if.wr_ready_o_fb) begin
        exp_q.push_back({(i == N - 1), frame[i]});
`ifdef FB_STATS_EN
        if (frame[i] < mn) mn = frame[i];
        if (frame[i] > mx) mx = frame[i];
`endif
        i++;
      end
      @(posedge clk); #1;
      budget++;
    end
    fb_if.wr_valid_i_fb = 1'b0;
    if (i < npix) chk("wr_timeout", 32'(i), 32'(npix));
    chk("wr_done_early", 32'(early), 32'd0);
    if (npix == N) begin
      @(negedge clk);
      chk("wr_done_pulse", 32'(fb_if.wr_done_o_fb), 32'd1);
      chk("full_set", 32'(fb_if.full_o_fb), 32'd1);
      chk("wr_ready_full", 32'(fb_if.wr_ready_o_fb), 32'd0);
`ifdef FB_STATS_EN
      chk("stat_min", 32'(fb_if.min_o_fb), 32'(mn));
      chk("stat_max", 32'(fb_if.max_o_fb), 32'(mx));
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_done_1cyc", 32'(fb_if.wr_done_o_fb), 32'd0);
      chk("full_hold", 32'(fb_if.full_o_fb), 32'd1);
    end
  endtask

  // mode 0: ready=1, mode 1: ready 1010..., mode 2: random ready
  task automatic read_frame(input int mode, input bit with_wr_start);
    int cyc;
    int base;
    cyc  = 0;
    base = n_rd_done;
    while (cyc < 400) begin
      @(posedge clk); #1;
      if (n_rd_done != base) break;
      fb_if.rd_start_i_fb = (cyc == 0);
      fb_if.wr_start_i_fb = with_wr_start && (cyc == 0);
      case (mode)
        0:       fb_if.rd_ready_i_fb = 1'b1;
        1:       fb_if.rd_ready_i_fb = ((cyc % 2) == 0);
        default: fb_if.rd_ready_i_fb = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (cyc == 0) t_start = cyc_cnt;
      if (cyc < 2)  chk("rd_lat_lo", 32'(fb_if.rd_valid_o_fb), 32'd0);
      if (cyc == 2) chk("rd_lat_hi", 32'(fb_if.rd_valid_o_fb), 32'd1);
      if (with_wr_start && cyc < 4) chk("wr_start_ign", 32'(fb_if.wr_ready_o_fb), 32'd0);
      cyc++;
    end
    fb_if.rd_start_i_fb = 1'b0;
    fb_if.wr_start_i_fb = 1'b0;
    fb_if.rd_ready_i_fb = 1'b0;
    chk("rd_done_cnt", 32'(n_rd_done - base), 32'd1);
    if (mode == 0) chk("rd_thruput", 32'(t_done - t_start), 32'(N + 1));
    @(negedge clk);
    chk("full_clr", 32'(fb_if.full_o_fb), 32'd0);
    chk("rd_idle", 32'(fb_if.rd_valid_o_fb), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fb_if.wr_start_i_fb = 1'b0;
    fb_if.wr_valid_i_fb = 1'b0;
    fb_if.wr_data_i_fb  = '0;
    fb_if.rd_start_i_fb = 1'b0;
    fb_if.rd_ready_i_fb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 32'(fb_if.wr_ready_o_fb), 32'd0);
    chk("rst_wr_done", 32'(fb_if.wr_done_o_fb), 32'd0);
    chk("rst_full", 32'(fb_if.full_o_fb), 32'd0);
    chk("rst_rd_valid", 32'(fb_if.rd_valid_o_fb), 32'd0);
    chk("rst_rd_data", 32'(fb_if.rd_data_o_fb), 32'd0);
    chk("rst_rd_last", 32'(fb_if.rd_last_o_fb), 32'd0);
    chk("rst_rd_done", 32'(fb_if.rd_done_o_fb), 32'd0);
`ifdef FB_STATS_EN
    chk("rst_min", 32'(fb_if.min_o_fb), 32'hFF);
    chk("rst_max", 32'(fb_if.max_o_fb), 32'h00);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ramp frame, full-rate then toggling ready
    for (int i = 0; i < N; i++) frame[i] = 8'(i);
    write_frame(100, N);
    read_frame(0, 1'b0);
    write_frame(100, N);
    read_frame(1, 1'b0);

    // rd_start while empty, wr_start while full
    @(posedge clk); #1;
    fb_if.rd_start_i_fb = 1'b1;
    fb_if.rd_ready_i_fb = 1'b1;
    @(posedge clk); #1;
    fb_if.rd_start_i_fb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rd_start_ign", 32'(fb_if.rd_valid_o_fb), 32'd0);
    end
    fb_if.rd_ready_i_fb = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = 8'hA0 + 8'(i);
    write_frame(100, N);
    @(posedge clk); #1;
    fb_if.wr_start_i_fb = 1'b1;
    @(posedge clk); #1;
    fb_if.wr_start_i_fb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wr_start_full_ign", 32'(fb_if.wr_ready_o_fb), 32'd0);
      chk("full_kept", 32'(fb_if.full_o_fb), 32'd1);
    end
    read_frame(0, 1'b1);

    // reset in the middle of a write
    for (int i = 0; i < N; i++) frame[i] = 8'h50 + 8'(i);
    write_frame(100, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wr_ready", 32'(fb_if.wr_ready_o_fb), 32'd0);
    chk("midrst_wr_done", 32'(fb_if.wr_done_o_fb), 32'd0);
    chk("midrst_full", 32'(fb_if.full_o_fb), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) frame[i] = 8'hC0 + 8'(3 * i);
    write_frame(100, N);
    read_frame(0, 1'b0);

    // min/max pattern
    frame[0] = 8'd9;  frame[1] = 8'd3;  frame[2] = 8'd200; frame[3] = 8'd17;
    frame[4] = 8'd50; frame[5] = 8'd60; frame[6] = 8'd70;  frame[7] = 8'd80;
    write_frame(100, N);
    read_frame(2, 1'b0);
`ifdef FB_STATS_EN
    chk("stat_min_hold", 32'(fb_if.min_o_fb), 32'd3);
    chk("stat_max_hold", 32'(fb_if.max_o_fb), 32'd200);
`endif

    // random valid / ready over several frames
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 255));
      write_frame(60, N);
      read_frame(2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
